// File: rtl/fetch_order_checker.sv
// In-order fetch request/response monitor with sticky error flags, counters and end-of-test PC detection.
// Optional macro FETCH_CHECK_ERR_CAPTURE_EN adds first-error address/cycle capture registers.
module fetch_order_checker #(
  parameter int                        ADDRESS_BITS = 12,
  parameter int                        DEPTH        = 2,
  parameter int                        CNT_BITS     = 32,
  parameter logic [ADDRESS_BITS-1:0]   END_PC       = 12'h0B0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        req_valid,
  input  logic [ADDRESS_BITS-1:0]     req_addr,
  input  logic                        rsp_valid,
  input  logic [ADDRESS_BITS-1:0]     rsp_addr,
  input  logic                        pc_valid,
  input  logic [ADDRESS_BITS-1:0]     pc_mem,
  output logic [$clog2(DEPTH):0]      outstanding,
  output logic                        full,
  output logic                        empty,
  output logic                        err_overflow,
  output logic                        err_order,
  output logic                        err_spurious,
  output logic [ADDRESS_BITS-1:0]     err_addr,
  output logic [CNT_BITS-1:0]         err_cycle,
  output logic [CNT_BITS-1:0]         cycle_count,
  output logic [CNT_BITS-1:0]         req_count,
  output logic [CNT_BITS-1:0]         rsp_count,
  output logic                        done,
  output logic [CNT_BITS-1:0]         done_cycles
);

  localparam int                PW       = $clog2(DEPTH);
  localparam int                OW       = PW + 1;
  localparam logic [OW-1:0]     FULL_LVL = OW'(DEPTH);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [ADDRESS_BITS-1:0] r_fifo [DEPTH];
  logic [PW-1:0]           r_head;
  logic [PW-1:0]           r_tail;
  logic [OW-1:0]           r_count;
  logic                    r_err_overflow;
  logic                    r_err_order;
  logic                    r_err_spurious;
  logic [CNT_BITS-1:0]     r_cycle_count;
  logic [CNT_BITS-1:0]     r_req_count;
  logic [CNT_BITS-1:0]     r_rsp_count;
  logic                    r_done;
  logic [CNT_BITS-1:0]     r_done_cycles;

  logic                    w_empty;
  logic                    w_full;
  logic [ADDRESS_BITS-1:0] w_head_addr;
  logic                    w_rsp_hit;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_err_order;
  logic                    w_err_spurious;
  logic                    w_err_overflow;
  logic                    w_done_hit;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FULL_LVL);
  assign w_head_addr = r_fifo[r_head];

  // Response is judged against the pre-cycle head; a full FIFO accepts a request only if the head pops.
  assign w_rsp_hit      = rsp_valid && !w_empty && (rsp_addr == w_head_addr);
  assign w_err_order    = rsp_valid && !w_empty && (rsp_addr != w_head_addr);
  assign w_err_spurious = rsp_valid && w_empty;
  assign w_err_overflow = req_valid && w_full && !w_rsp_hit;
  assign w_pop          = w_rsp_hit && !r_done;
  assign w_push         = req_valid && (!w_full || w_rsp_hit) && !r_done;
  assign w_done_hit     = pc_valid && (pc_mem == END_PC);

  // NOTE: storage is deliberately not reset; entries are only ever read when occupancy marks them valid.
  always_ff @(posedge clock) begin
    if (w_push) r_fifo[r_tail] <= req_addr;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop)  r_head <= r_head + PW'(1);
      if (w_push) r_tail <= r_tail + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OW'(1);
        2'b01:   r_count <= r_count - OW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err_overflow <= 1'b0;
      r_err_order    <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      if (w_err_overflow) r_err_overflow <= 1'b1;
      if (w_err_order)    r_err_order    <= 1'b1;
      if (w_err_spurious) r_err_spurious <= 1'b1;
    end
  end

  // Counters saturate and freeze once done is set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle_count <= '0;
      r_req_count   <= '0;
      r_rsp_count   <= '0;
      r_done        <= 1'b0;
      r_done_cycles <= '0;
    end else begin
      if (!r_done && r_cycle_count != CNT_MAX) r_cycle_count <= r_cycle_count + CNT_BITS'(1);
      if (w_push && r_req_count != CNT_MAX)    r_req_count   <= r_req_count + CNT_BITS'(1);
      if (w_pop && r_rsp_count != CNT_MAX)     r_rsp_count   <= r_rsp_count + CNT_BITS'(1);
      if (!r_done && w_done_hit) begin
        r_done        <= 1'b1;
        r_done_cycles <= r_cycle_count;
      end
    end
  end

`ifdef FETCH_CHECK_ERR_CAPTURE_EN
  logic [ADDRESS_BITS-1:0] r_err_addr;
  logic [CNT_BITS-1:0]     r_err_cycle;
  logic                    w_err_seen;
  logic                    w_err_now;

  assign w_err_seen = r_err_overflow || r_err_order || r_err_spurious;
  assign w_err_now  = w_err_order || w_err_spurious || w_err_overflow;

  // Order and spurious are mutually exclusive, so preferring rsp_addr gives order > spurious > overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err_addr  <= '0;
      r_err_cycle <= '0;
    end else if (!w_err_seen && w_err_now) begin
      r_err_addr  <= (w_err_order || w_err_spurious) ? rsp_addr : req_addr;
      r_err_cycle <= r_cycle_count;
    end
  end

  assign err_addr  = r_err_addr;
  assign err_cycle = r_err_cycle;
`else
  assign err_addr  = '0;
  assign err_cycle = '0;
`endif

  assign outstanding  = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign err_overflow = r_err_overflow;
  assign err_order    = r_err_order;
  assign err_spurious = r_err_spurious;
  assign cycle_count  = r_cycle_count;
  assign req_count    = r_req_count;
  assign rsp_count    = r_rsp_count;
  assign done         = r_done;
  assign done_cycles  = r_done_cycles;

endmodule

// File: tb/tb_fetch_order_checker.sv
// Directed bench for fetch_order_checker: DEPTH=2 vector table plus hand-written corner sequences, DEPTH=4 in-order run.
module tb_fetch_order_checker;

  localparam int AB = 12;
  localparam int CB = 32;
`ifdef FETCH_CHECK_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [AB-1:0] req_addr;
  logic          rsp_valid;
  logic [AB-1:0] rsp_addr;
  logic          pc_valid;
  logic [AB-1:0] pc_mem;

  logic [1:0]    o2_outstanding;
  logic          o2_full, o2_empty, o2_err_overflow, o2_err_order, o2_err_spurious, o2_done;
  logic [AB-1:0] o2_err_addr;
  logic [CB-1:0] o2_err_cycle, o2_cycle_count, o2_req_count, o2_rsp_count, o2_done_cycles;

  logic [2:0]    o4_outstanding;
  logic          o4_full, o4_empty, o4_err_overflow, o4_err_order, o4_err_spurious, o4_done;
  logic [AB-1:0] o4_err_addr;
  logic [CB-1:0] o4_err_cycle, o4_cycle_count, o4_req_count, o4_rsp_count, o4_done_cycles;

  int n_checked = 0;
  int n_failed  = 0;

  always #5 clock = ~clock;

  fetch_order_checker #(.ADDRESS_BITS(AB), .DEPTH(2), .CNT_BITS(CB), .END_PC(12'h0B0)) u_dut2 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_addr(rsp_addr),
    .pc_valid(pc_valid), .pc_mem(pc_mem),
    .outstanding(o2_outstanding), .full(o2_full), .empty(o2_empty),
    .err_overflow(o2_err_overflow), .err_order(o2_err_order), .err_spurious(o2_err_spurious),
    .err_addr(o2_err_addr), .err_cycle(o2_err_cycle), .cycle_count(o2_cycle_count),
    .req_count(o2_req_count), .rsp_count(o2_rsp_count), .done(o2_done), .done_cycles(o2_done_cycles)
  );

  fetch_order_checker #(.ADDRESS_BITS(AB), .DEPTH(4), .CNT_BITS(CB), .END_PC(12'h0B0)) u_dut4 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_addr(rsp_addr),
    .pc_valid(pc_valid), .pc_mem(pc_mem),
    .outstanding(o4_outstanding), .full(o4_full), .empty(o4_empty),
    .err_overflow(o4_err_overflow), .err_order(o4_err_order), .err_spurious(o4_err_spurious),
    .err_addr(o4_err_addr), .err_cycle(o4_err_cycle), .cycle_count(o4_cycle_count),
    .req_count(o4_req_count), .rsp_count(o4_rsp_count), .done(o4_done), .done_cycles(o4_done_cycles)
  );

  typedef struct {
    logic          req_v;
    logic [AB-1:0] req_a;
    logic          rsp_v;
    logic [AB-1:0] rsp_a;
    logic [1:0]    e_out;
    logic          e_ovf;
    logic          e_ord;
    logic          e_spur;
    logic [3:0]    e_req;
    logic [3:0]    e_rsp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checked++;
    if (actual !== expected) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step(input logic rv, input logic [AB-1:0] ra, input logic sv, input logic [AB-1:0] sa,
                      input logic pv, input logic [AB-1:0] pa);
    req_valid = rv; req_addr = ra;
    rsp_valid = sv; rsp_addr = sa;
    pc_valid  = pv; pc_mem   = pa;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_addr = '0;
    rsp_valid = 1'b0; rsp_addr = '0;
    pc_valid  = 1'b0; pc_mem   = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".outstanding"},  64'(o2_outstanding),  64'(0));
    check({tag, ".empty"},        64'(o2_empty),        64'(1));
    check({tag, ".full"},         64'(o2_full),         64'(0));
    check({tag, ".err_overflow"}, 64'(o2_err_overflow), 64'(0));
    check({tag, ".err_order"},    64'(o2_err_order),    64'(0));
    check({tag, ".err_spurious"}, 64'(o2_err_spurious), 64'(0));
    check({tag, ".err_addr"},     64'(o2_err_addr),     64'(0));
    check({tag, ".err_cycle"},    64'(o2_err_cycle),    64'(0));
    check({tag, ".cycle_count"},  64'(o2_cycle_count),  64'(0));
    check({tag, ".req_count"},    64'(o2_req_count),    64'(0));
    check({tag, ".rsp_count"},    64'(o2_rsp_count),    64'(0));
    check({tag, ".done"},         64'(o2_done),         64'(0));
    check({tag, ".done_cycles"},  64'(o2_done_cycles),  64'(0));
  endtask

  initial begin
    // DEPTH=2 stream: fill, overflow, pop-then-push at full, order error, spurious with same-cycle push.
    vecs[0] = '{1'b1, 12'h010, 1'b0, 12'h000, 2'd1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0};
    vecs[1] = '{1'b1, 12'h014, 1'b0, 12'h000, 2'd2, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0};
    vecs[2] = '{1'b1, 12'h018, 1'b0, 12'h000, 2'd2, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0};
    vecs[3] = '{1'b1, 12'h018, 1'b1, 12'h010, 2'd2, 1'b1, 1'b0, 1'b0, 4'd3, 4'd1};
    vecs[4] = '{1'b0, 12'h000, 1'b1, 12'h014, 2'd1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd2};
    vecs[5] = '{1'b0, 12'h000, 1'b1, 12'h01C, 2'd1, 1'b1, 1'b1, 1'b0, 4'd3, 4'd2};
    vecs[6] = '{1'b0, 12'h000, 1'b1, 12'h018, 2'd0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd3};
    vecs[7] = '{1'b1, 12'h040, 1'b1, 12'h040, 2'd1, 1'b1, 1'b1, 1'b1, 4'd4, 4'd3};
    vecs[8] = '{1'b0, 12'h000, 1'b1, 12'h040, 2'd0, 1'b1, 1'b1, 1'b1, 4'd4, 4'd4};

    idle_inputs();
    reset = 1'b0;
    #2;
    check_reset_state("init");

    apply_reset();
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].req_v, vecs[i].req_a, vecs[i].rsp_v, vecs[i].rsp_a, 1'b0, 12'h000);
      check($sformatf("v%0d.outstanding", i),  64'(o2_outstanding),  64'(vecs[i].e_out));
      check($sformatf("v%0d.full", i),         64'(o2_full),         64'(vecs[i].e_out == 2'd2));
      check($sformatf("v%0d.empty", i),        64'(o2_empty),        64'(vecs[i].e_out == 2'd0));
      check($sformatf("v%0d.err_overflow", i), 64'(o2_err_overflow), 64'(vecs[i].e_ovf));
      check($sformatf("v%0d.err_order", i),    64'(o2_err_order),    64'(vecs[i].e_ord));
      check($sformatf("v%0d.err_spurious", i), 64'(o2_err_spurious), 64'(vecs[i].e_spur));
      check($sformatf("v%0d.req_count", i),    64'(o2_req_count),    64'(vecs[i].e_req));
      check($sformatf("v%0d.rsp_count", i),    64'(o2_rsp_count),    64'(vecs[i].e_rsp));
    end
    check("ovf.err_addr",  64'(o2_err_addr),  CAP ? 64'h018 : 64'h0);
    check("ovf.err_cycle", 64'(o2_err_cycle), CAP ? 64'd2   : 64'h0);

    // DEPTH=4: three requests then in-order responses.
    apply_reset();
    step(1'b1, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000);
    step(1'b1, 12'h004, 1'b0, 12'h000, 1'b0, 12'h000);
    step(1'b1, 12'h008, 1'b0, 12'h000, 1'b0, 12'h000);
    check("d4.outstanding3", 64'(o4_outstanding), 64'd3);
    check("d4.full3",        64'(o4_full),        64'd0);
    step(1'b0, 12'h000, 1'b1, 12'h000, 1'b0, 12'h000);
    step(1'b0, 12'h000, 1'b1, 12'h004, 1'b0, 12'h000);
    step(1'b0, 12'h000, 1'b1, 12'h008, 1'b0, 12'h000);
    check("d4.rsp_count",    64'(o4_rsp_count),   64'd3);
    check("d4.req_count",    64'(o4_req_count),   64'd3);
    check("d4.outstanding0", 64'(o4_outstanding), 64'd0);
    check("d4.errors",       64'({o4_err_overflow, o4_err_order, o4_err_spurious}), 64'd0);

    // Order error as first error, head retained, later matching response pops.
    apply_reset();
    step(1'b1, 12'h030, 1'b0, 12'h000, 1'b0, 12'h000);
    step(1'b0, 12'h000, 1'b1, 12'h034, 1'b0, 12'h000);
    check("ord.err_order",   64'(o2_err_order),   64'd1);
    check("ord.outstanding", 64'(o2_outstanding), 64'd1);
    check("ord.err_addr",    64'(o2_err_addr),    CAP ? 64'h034 : 64'h0);
    check("ord.err_cycle",   64'(o2_err_cycle),   CAP ? 64'd1   : 64'h0);
    step(1'b0, 12'h000, 1'b1, 12'h030, 1'b0, 12'h000);
    check("ord.pop_out",     64'(o2_outstanding), 64'd0);
    check("ord.pop_rsp",     64'(o2_rsp_count),   64'd1);

    // Spurious response with a same-cycle request.
    apply_reset();
    step(1'b1, 12'h040, 1'b1, 12'h044, 1'b0, 12'h000);
    check("spur.err_spurious", 64'(o2_err_spurious), 64'd1);
    check("spur.outstanding",  64'(o2_outstanding),  64'd1);
    check("spur.rsp_count",    64'(o2_rsp_count),    64'd0);
    check("spur.err_addr",     64'(o2_err_addr),     CAP ? 64'h044 : 64'h0);

    // Completion at cycle 57, then freeze of counters/FIFO while errors still set.
    apply_reset();
    step(1'b1, 12'h050, 1'b0, 12'h000, 1'b0, 12'h000);
    for (int i = 1; i < 57; i++) begin
      step(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, (i == 10) ? 12'h0B0 : 12'h000);
      if (i == 10) check("done.no_pc_valid", 64'(o2_done), 64'd0);
    end
    check("done.pre_cycle", 64'(o2_cycle_count), 64'd57);
    step(1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 12'h0B0);
    check("done.flag",        64'(o2_done),        64'd1);
    check("done.done_cycles", 64'(o2_done_cycles), 64'd57);
    check("done.cycle_count", 64'(o2_cycle_count), 64'd58);
    step(1'b1, 12'h060, 1'b1, 12'h070, 1'b0, 12'h000);
    step(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000);
    check("frz.cycle_count", 64'(o2_cycle_count), 64'd58);
    check("frz.req_count",   64'(o2_req_count),   64'd1);
    check("frz.outstanding", 64'(o2_outstanding), 64'd1);
    check("frz.done_cycles", 64'(o2_done_cycles), 64'd57);
    check("frz.err_order",   64'(o2_err_order),   64'd1);
    check("frz.err_addr",    64'(o2_err_addr),    CAP ? 64'h070 : 64'h0);
    check("frz.err_cycle",   64'(o2_err_cycle),   CAP ? 64'd58  : 64'h0);

    // Asynchronous mid-test reset, sampled between clock edges.
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("async");
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_failed);
    $finish;
  end

endmodule
